tree_vote_scheduler: RTL and testbench
======================================

Name: tree_vote_scheduler

Overview:
- Sequences one feature vector through a bank of combinational decision-tree classifiers, one classifier per class per tree index (classN_treeM style).
- The trees share one feature bus and one tree-select mux; this block drives them and time-multiplexes the tree indices.
- It accumulates one-vs-rest votes per class, then emits the argmax class over a valid/ready handshake.
- Sits between the feature capture front end and the result consumer.

Parameters:
N_FEAT, 51, feature vector width (matches tree input i)
N_CLASS, 7, number of classes / per-class tree outputs per tree index
N_TREE, 3, tree indices per class, evaluated sequentially
SETTLE, 2, wait cycles after changing tree_sel before sampling hits (range 0..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  feature vector valid
in_ready  out  1  block can accept a vector
in_feat  in  N_FEAT  feature vector
flush  in  1  synchronous abort to IDLE
feat_o  out  N_FEAT  registered feature bus to tree bank
tree_sel_o  out  clog2(N_TREE)  tree index selected in bank mux
hit_i  in  N_CLASS  tree outputs o for the selected tree index, bit k = class k
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
class_o  out  clog2(N_CLASS)  winning class
votes_o  out  clog2(N_TREE+1)  vote count of winner
no_vote_o  out  1  all vote counts zero
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1, out_valid=0, busy=0; feat_o, tree_sel_o, class_o, votes_o all 0; no_vote_o=0; vote counters and wait counter cleared.
- States: IDLE, WAIT, SAMPLE, DECIDE, OUT.
- IDLE: in_ready=1. On in_valid&in_ready, capture in_feat into feat_o, set tree_sel_o=0, clear all counters and wait_cnt, then go to WAIT (or SAMPLE if SETTLE=0).
- WAIT: wait_cnt increments each cycle. When wait_cnt==SETTLE-1, go to SAMPLE.
- SAMPLE: one cycle.
  - For each k with hit_i[k]=1, vote[k] += 1. Counters are clog2(N_TREE+1) bits wide and cannot overflow.
  - If tree_sel_o==N_TREE-1, go to DECIDE.
  - Otherwise increment tree_sel_o, clear wait_cnt, and go to WAIT (or SAMPLE if SETTLE=0).
- Each tree index occupies exactly SETTLE+1 cycles. feat_o is stable from capture until return to IDLE.
- DECIDE: one cycle. Argmax over vote[0..N_CLASS-1]; ties go to the lowest class index. Register class_o, votes_o, and no_vote_o (set when the max is 0; class_o=0 in that case). Go to OUT.
- OUT: out_valid=1. class_o, votes_o, and no_vote_o are held stable while out_valid&!out_ready. On out_ready, go to IDLE and clear out_valid. in_ready stays 0 until IDLE.
- Latency: with defaults, out_valid rises 10 cycles after the accepting edge. General formula: N_TREE*(SETTLE+1)+1.
- flush: highest priority after rst. From any state, go to IDLE the next edge. out_valid drops, counters clear, and result registers keep their last values. Flush in IDLE is a no-op. Flush coincident with in_valid in IDLE: the vector is not accepted.
- hit_i is sampled only in SAMPLE; it is a don't-care elsewhere.
- tree_sel_o never exceeds N_TREE-1, and it returns to 0 on entering IDLE.

Test Plan:
- Reset mid-WAIT (tree_sel_o=1): assert rst asynchronously → all outputs reset immediately. After release, in_ready=1 and the next vector gives a clean result.
- Single vote: hit_i=7'b0000100 at every SAMPLE, defaults → out_valid 10 cycles after accept, class_o=2, votes_o=3, no_vote_o=0. tree_sel_o sequence is 0,0,0,1,1,1,2,2,2.
- Tie-break: tree0 hit 7'b0100010, tree1 hit 7'b0100010, tree2 hit 0 → class_o=1, votes_o=2.
- No vote: hit_i=0 throughout → class_o=0, votes_o=0, no_vote_o=1.
- Backpressure: out_ready=0 for 5 cycles in OUT → out_valid and class_o stable, in_ready=0, and in_valid is ignored. Result is accepted on the cycle out_ready=1, and in_ready=1 on the next cycle.
- Flush in SAMPLE of tree 1, then a new vector with hit_i=7'b1000000 → out_valid=0 immediately after the flush. New result is class_o=6, votes_o=3, with no leftover votes from the aborted vector.
- SETTLE=0 build: each tree index takes 1 cycle → latency 4; same single-vote result as above.

Source files
------------

// File: rtl/tree_vote_scheduler.sv
// rtl/tree_vote_scheduler.sv - sequences one feature vector through a tree bank and votes
//
// Purpose: captures a feature vector, steps the shared tree-select mux through
// every tree index (waiting SETTLE cycles for the combinational trees to settle
// before each sample), accumulates one-vs-rest votes per class and presents the
// argmax class over a valid/ready handshake.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   feature vector handshake, in_feat = vector
//   flush               synchronous abort back to IDLE
//   feat_o              registered feature bus to the tree bank
//   tree_sel_o          tree index driven into the bank mux
//   hit_i               tree outputs for the selected index, bit k = class k
//   out_valid/out_ready result handshake
//   class_o, votes_o    winning class and its vote count
//   no_vote_o           every class received zero votes
//   busy                block is not in IDLE
module tree_vote_scheduler #(
  parameter int N_FEAT  = 51,
  parameter int N_CLASS = 7,
  parameter int N_TREE  = 3,
  parameter int SETTLE  = 2,
  localparam int TSW    = (N_TREE > 1) ? $clog2(N_TREE) : 1,
  localparam int CW     = (N_CLASS > 1) ? $clog2(N_CLASS) : 1,
  localparam int VW     = $clog2(N_TREE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_FEAT-1:0] in_feat,
  input  logic              flush,
  output logic [N_FEAT-1:0] feat_o,
  output logic [TSW-1:0]    tree_sel_o,
  input  logic [N_CLASS-1:0] hit_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     class_o,
  output logic [VW-1:0]     votes_o,
  output logic              no_vote_o,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SAMPLE = 3'd2,
    S_DECIDE = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [TSW-1:0] TREE_LAST   = TSW'(N_TREE - 1);

  state_t                     state_q, state_d;
  logic [3:0]                 wait_cnt_q;
  logic [TSW-1:0]             tree_sel_q;
  logic [N_FEAT-1:0]          feat_q;
  logic [N_CLASS-1:0][VW-1:0] vote_q;
  logic [CW-1:0]              class_q;
  logic [VW-1:0]              votes_q;
  logic                       no_vote_q;

  logic [CW-1:0]              best_cls;
  logic [VW-1:0]              best_v;

  // With SETTLE=0 there is no wait phase: a tree index is sampled on the
  // first cycle it is selected.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (in_valid) state_d = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
      S_WAIT:   if (wait_cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
      S_SAMPLE: begin
        if (tree_sel_q == TREE_LAST) state_d = S_DECIDE;
        else                         state_d = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
      end
      S_DECIDE: state_d = S_OUT;
      S_OUT:    if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Argmax with strict '>' so ties keep the lowest class index, and an
  // all-zero vote vector naturally yields class 0.
  always_comb begin
    best_cls = '0;
    best_v   = vote_q[0];
    for (int k = 1; k < N_CLASS; k++) begin
      if (vote_q[k] > best_v) begin
        best_v   = vote_q[k];
        best_cls = CW'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      tree_sel_q <= '0;
      feat_q     <= '0;
      vote_q     <= '0;
      class_q    <= '0;
      votes_q    <= '0;
      no_vote_q  <= 1'b0;
    end else if (flush) begin
      // Result registers deliberately keep their last values on abort.
      wait_cnt_q <= '0;
      tree_sel_q <= '0;
      vote_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            feat_q     <= in_feat;
            tree_sel_q <= '0;
            wait_cnt_q <= '0;
            vote_q     <= '0;
          end
        end
        S_WAIT: wait_cnt_q <= wait_cnt_q + 4'd1;
        S_SAMPLE: begin
          for (int k = 0; k < N_CLASS; k++) begin
            vote_q[k] <= vote_q[k] + VW'(hit_i[k]);
          end
          if (tree_sel_q != TREE_LAST) begin
            tree_sel_q <= tree_sel_q + TSW'(1);
            wait_cnt_q <= '0;
          end
        end
        S_DECIDE: begin
          class_q   <= best_cls;
          votes_q   <= best_v;
          no_vote_q <= (best_v == '0);
        end
        S_OUT: if (out_ready) tree_sel_q <= '0;
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_OUT);
  assign busy       = (state_q != S_IDLE);
  assign feat_o     = feat_q;
  assign tree_sel_o = tree_sel_q;
  assign class_o    = class_q;
  assign votes_o    = votes_q;
  assign no_vote_o  = no_vote_q;

endmodule

// File: tb/tb_tree_vote_scheduler.sv
// tb/tb_tree_vote_scheduler.sv - scoreboard bench for tree_vote_scheduler
module tb_tree_vote_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, no_vote, busy;
  logic [50:0] in_feat, feat;
  logic [1:0]  tree_sel;
  logic [6:0]  hit;
  logic [2:0]  cls;
  logic [1:0]  votes;

  logic        in_valid_z, in_ready_z, flush_z, out_valid_z, out_ready_z, no_vote_z, busy_z;
  logic [50:0] in_feat_z, feat_z;
  logic [1:0]  tree_sel_z;
  logic [6:0]  hit_z;
  logic [2:0]  cls_z;
  logic [1:0]  votes_z;

  logic [6:0]  pat [4];
  assign hit   = pat[tree_sel];
  assign hit_z = 7'b0000100;

  tree_vote_scheduler u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .flush(flush), .feat_o(feat), .tree_sel_o(tree_sel), .hit_i(hit),
    .out_valid(out_valid), .out_ready(out_ready), .class_o(cls), .votes_o(votes),
    .no_vote_o(no_vote), .busy(busy)
  );

  tree_vote_scheduler #(.SETTLE(0)) u_dut_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_z), .in_ready(in_ready_z), .in_feat(in_feat_z),
    .flush(flush_z), .feat_o(feat_z), .tree_sel_o(tree_sel_z), .hit_i(hit_z),
    .out_valid(out_valid_z), .out_ready(out_ready_z), .class_o(cls_z), .votes_o(votes_z),
    .no_vote_o(no_vote_z), .busy(busy_z)
  );

  typedef struct {
    logic [2:0] c;
    logic [1:0] v;
    logic       nv;
    int         lat;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   lat = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: timestamps acceptance, measures latency to out_valid and pops
  // the scoreboard on every result handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready && !flush) acc_cyc = cyc + 1;
      if (out_valid && !prev_ov) lat = cyc - acc_cyc;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = q.pop_front();
          chk("class_o", cls, e.c);
          chk("votes_o", votes, e.v);
          chk("no_vote_o", no_vote, e.nv);
          chk("latency", lat, e.lat);
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic run_vec(input logic [50:0] f, input logic [6:0] h0, input logic [6:0] h1,
                         input logic [6:0] h2, input bit push, input logic [2:0] ec,
                         input logic [1:0] ev, input logic en);
    exp_t x;
    pat[0] = h0; pat[1] = h1; pat[2] = h2; pat[3] = 7'h0;
    if (push) begin
      x.c = ec; x.v = ev; x.nv = en; x.lat = 10;
      q.push_back(x);
    end
    in_feat  = f;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (out_valid && out_ready) found = 1'b1;
    end
    if (!found) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] held_c;
    bit         seen;
    int         n;

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_feat = '0;
    in_valid_z = 1'b0; flush_z = 1'b0; out_ready_z = 1'b1; in_feat_z = '0;
    pat[0] = '0; pat[1] = '0; pat[2] = '0; pat[3] = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_feat", feat, 0);
    chk("rst_tree_sel", tree_sel, 0);
    chk("rst_class", cls, 0);
    chk("rst_votes", votes, 0);
    chk("rst_no_vote", no_vote, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single vote, with the tree_sel_o walk checked cycle by cycle.
    run_vec(51'h1_2345_6789_ABCD, 7'b0000100, 7'b0000100, 7'b0000100, 1, 3'd2, 2'd3, 1'b0);
    for (int i = 0; i < 9; i++) begin
      chk("tree_sel_seq", tree_sel, i / 3);
      @(posedge clk); #1;
    end
    chk("feat_o_captured", feat, 51'h1_2345_6789_ABCD);
    wait_done();

    // Tie between classes 1 and 5 resolves to the lower index.
    run_vec(51'h0_0000_0000_0011, 7'b0100010, 7'b0100010, 7'b0000000, 1, 3'd1, 2'd2, 1'b0);
    wait_done();

    // No votes at all.
    run_vec(51'h7_FFFF_FFFF_FFFF, 7'b0, 7'b0, 7'b0, 1, 3'd0, 2'd0, 1'b1);
    wait_done();

    // Backpressure: result held, new vectors ignored.
    out_ready = 1'b0;
    run_vec(51'h0_0000_0000_0BAD, 7'b0010000, 7'b0010000, 7'b0010000, 1, 3'd4, 2'd3, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) chk("bp_out_valid_timeout", 0, 1);
    held_c    = cls;
    in_feat   = 51'h5_5555_5555_5555;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_class_stable", cls, held_c);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_out_valid_after", out_valid, 0);
    chk("bp_feat_kept", feat, 51'h0_0000_0000_0BAD);

    // Flush during SAMPLE of tree 1; aborted votes must not leak.
    run_vec(51'h0_0000_0000_0F0F, 7'b1111111, 7'b1111111, 7'b1111111, 0, 3'd0, 2'd0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("flush_pre_tree_sel", tree_sel, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_tree_sel", tree_sel, 0);
    run_vec(51'h0_0000_0000_0066, 7'b1000000, 7'b1000000, 7'b1000000, 1, 3'd6, 2'd3, 1'b0);
    wait_done();

    // Flush coincident with in_valid in IDLE does not accept.
    in_feat = 51'h0_0000_0000_0777; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", busy, 0);
    chk("flush_idle_feat", feat, 51'h0_0000_0000_0066);

    // Asynchronous reset in WAIT of tree 1.
    run_vec(51'h0_0000_0000_0999, 7'b0000001, 7'b0000001, 7'b0000001, 0, 3'd0, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst2_pre_tree_sel", tree_sel, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst2_tree_sel", tree_sel, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_feat", feat, 0);
    chk("rst2_class", cls, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_vec(51'h0_0000_0000_0333, 7'b0001000, 7'b0001000, 7'b0001000, 1, 3'd3, 2'd3, 1'b0);
    wait_done();

    // SETTLE=0 build: latency N_TREE+1.
    in_feat_z  = 51'h0_0000_0000_0123;
    in_valid_z = 1'b1;
    @(posedge clk); #1;
    in_valid_z = 1'b0;
    n = 0;
    while (!out_valid_z && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s0_latency", n, 4);
    chk("s0_class", cls_z, 2);
    chk("s0_votes", votes_z, 3);
    chk("s0_no_vote", no_vote_z, 0);
    @(posedge clk); #1;
    chk("s0_in_ready_after", in_ready_z, 1);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
